// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory-access pipeline stage.
// Holds the access FSM state encoding and a constant-evaluable log2 helper.
package mem_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   localparam int DEF_DEPTH   = 256;
   localparam int DEF_MEM_LAT = 1;

   // Ceiling log2; usable in parameter expressions.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM-to-MEM/WB bundle: EX/MEM fields in, MEM/WB fields and Stall out.
// master = upstream/environment side, slave = the memory stage itself.
interface mem_stage_if;

   logic        RegWrite;
   logic        MemtoReg;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] Result;
   logic [31:0] RtData;
   logic [4:0]  MuxIn;

   logic        RegWriteOut;
   logic        MemtoRegOut;
   logic [31:0] ReadDataOut;
   logic [31:0] ResultOut;
   logic [4:0]  MuxOut;
   logic        Stall;

   modport master (
      output RegWrite, MemtoReg, MemWrite, MemRead, Result, RtData, MuxIn,
      input  RegWriteOut, MemtoRegOut, ReadDataOut, ResultOut, MuxOut, Stall
   );

   modport slave (
      input  RegWrite, MemtoReg, MemWrite, MemRead, Result, RtData, MuxIn,
      output RegWriteOut, MemtoRegOut, ReadDataOut, ResultOut, MuxOut, Stall
   );

endinterface

// File: rtl/data_mem.sv
// DEPTH x 32 data memory: synchronous write, asynchronous read on a shared index.
// Contents are never cleared by reset.
module data_mem
   import mem_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: load/store with MEM_LAT-cycle access, MEM/WB register, upstream Stall.
// Stalled cycles push bubbles (write enables low, data fields held) into MEM/WB.
module mem_stage
   import mem_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int ADDR_W  = clog2(DEPTH),
   parameter int MEM_LAT = DEF_MEM_LAT
) (
   input  logic      clk,
   input  logic      rst,
   mem_stage_if.slave bus
);

   localparam int              CNT_W    = (MEM_LAT > 1) ? clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               acc;
   logic               complete;
   logic               stall;
   logic               mem_we;
   logic [ADDR_W-1:0]  word_idx;
   logic [31:0]        rd_data;
   logic               unused_addr_bits;

   logic               reg_write_q, reg_write_d;
   logic               mem_to_reg_q, mem_to_reg_d;
   logic [31:0]        read_data_q, read_data_d;
   logic [31:0]        result_q, result_d;
   logic [4:0]         mux_q, mux_d;

   // Byte address -> word index; upper bits wrap modulo DEPTH.
   assign word_idx         = bus.Result[ADDR_W+1:2];
   assign unused_addr_bits = ^{bus.Result[31:ADDR_W+2], bus.Result[1:0]};

   assign acc = bus.MemRead | bus.MemWrite;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      complete = 1'b0;
      case (state_q)
         IDLE: begin
            if (acc) begin
               if (MEM_LAT == 1) begin
                  complete = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == CNT_LAST) begin
               complete = 1'b1;
               state_d  = IDLE;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign stall     = acc & ~complete & ~rst;
   assign bus.Stall = stall;
   assign mem_we    = complete & bus.MemWrite & ~rst;

   data_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_data_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .addr_i  (word_idx),
      .wdata_i (bus.RtData),
      .rdata_o (rd_data)
   );

   always_comb begin
      reg_write_d  = reg_write_q;
      mem_to_reg_d = mem_to_reg_q;
      read_data_d  = read_data_q;
      result_d     = result_q;
      mux_d        = mux_q;
      if (stall) begin
         reg_write_d  = 1'b0;
         mem_to_reg_d = 1'b0;
      end else begin
         reg_write_d  = bus.RegWrite;
         mem_to_reg_d = bus.MemtoReg;
         result_d     = bus.Result;
         mux_d        = bus.MuxIn;
         // A simultaneous read+write is treated as a store only.
         read_data_d  = (bus.MemRead && !bus.MemWrite) ? rd_data : 32'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         read_data_q  <= '0;
         result_q     <= '0;
         mux_q        <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         reg_write_q  <= reg_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         read_data_q  <= read_data_d;
         result_q     <= result_d;
         mux_q        <= mux_d;
      end
   end

   assign bus.RegWriteOut = reg_write_q;
   assign bus.MemtoRegOut = mem_to_reg_q;
   assign bus.ReadDataOut = read_data_q;
   assign bus.ResultOut   = result_q;
   assign bus.MuxOut      = mux_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: three instances with MEM_LAT = 1, 3, 4 driven independently.
// Expected MEM/WB values are queued when an op is issued and popped when it retires.
module tb_mem_stage;
   import mem_pkg::*;

   typedef struct packed {
      logic        rw;
      logic        m2r;
      logic        mw;
      logic        mr;
      logic [31:0] res;
      logic [31:0] rt;
      logic [4:0]  mux;
   } op_t;

   typedef struct packed {
      logic        rw;
      logic        m2r;
      logic [31:0] rd;
      logic [31:0] res;
      logic [4:0]  mux;
   } out_t;

   typedef struct {
      out_t o;
      int   nst;
   } sb_t;

   logic   clk;
   logic   rst_a   [3];
   op_t    drv     [3];
   out_t   obs     [3];
   logic   stall_a [3];

   sb_t         sb[$];
   logic [31:0] model [3][256];
   int          n_checks;
   int          n_fail;

   mem_stage_if bus [3] ();

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
      assign bus[g].RegWrite = drv[g].rw;
      assign bus[g].MemtoReg = drv[g].m2r;
      assign bus[g].MemWrite = drv[g].mw;
      assign bus[g].MemRead  = drv[g].mr;
      assign bus[g].Result   = drv[g].res;
      assign bus[g].RtData   = drv[g].rt;
      assign bus[g].MuxIn    = drv[g].mux;
      assign obs[g]     = {bus[g].RegWriteOut, bus[g].MemtoRegOut, bus[g].ReadDataOut,
                           bus[g].ResultOut, bus[g].MuxOut};
      assign stall_a[g] = bus[g].Stall;

      mem_stage #(
         .DEPTH   (256),
         .ADDR_W  (8),
         .MEM_LAT (LAT)
      ) u_dut (
         .clk (clk),
         .rst (rst_a[g]),
         .bus (bus[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
   endfunction

   function automatic op_t mk(input logic rw, input logic m2r, input logic mw, input logic mr,
                              input logic [31:0] res, input logic [31:0] rt, input logic [4:0] mux);
      op_t o;
      o.rw = rw; o.m2r = m2r; o.mw = mw; o.mr = mr;
      o.res = res; o.rt = rt; o.mux = mux;
      return o;
   endfunction

   // Issue one op at posedge+1, follow it to retirement, report what was seen.
   task automatic run_op(input int d, input op_t op, output out_t got, output int nst,
                         output int bub_bad);
      sb_t  e;
      out_t prev;
      int   idx;
      bit   done;
      idx      = int'(op.res[9:2]);
      e.o.rw   = op.rw;
      e.o.m2r  = op.m2r;
      e.o.res  = op.res;
      e.o.mux  = op.mux;
      e.o.rd   = (op.mr && !op.mw) ? model[d][idx] : 32'd0;
      e.nst    = (op.mr || op.mw) ? lat_of(d) - 1 : 0;
      if (op.mw) model[d][idx] = op.rt;
      sb.push_back(e);
      prev    = obs[d];
      drv[d]  = op;
      nst     = 0;
      bub_bad = 0;
      done    = 0;
      got     = 'x;
      while (!done) begin
         @(negedge clk);
         if (stall_a[d] === 1'b1) begin
            nst++;
            @(posedge clk); #1;
            if (obs[d].rw !== 1'b0 || obs[d].m2r !== 1'b0 || obs[d].rd !== prev.rd ||
                obs[d].res !== prev.res || obs[d].mux !== prev.mux)
               bub_bad++;
            if (nst > 20) done = 1;
         end else begin
            @(posedge clk); #1;
            got  = obs[d];
            done = 1;
         end
      end
      drv[d] = '0;
   endtask

   task automatic test_reset;
      for (int d = 0; d < 3; d++) begin
         rst_a[d] = 1'b1;
         drv[d]   = mk(1, 1, 0, 1, 32'h40, 32'h0, 5'd4);
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         n_checks++;
         if (obs[d] !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs dut%0d: got %h, expected 0", d, obs[d]);
         end
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         n_checks++;
         if (stall_a[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall dut%0d: got %b, expected 0", d, stall_a[d]);
         end
      end
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
         rst_a[d] = 1'b0;
         drv[d]   = '0;
      end
   endtask

   task automatic test_store_load;
      op_t  ops [3];
      out_t got;
      int   nst, bub;
      sb_t  e;
      ops[0] = mk(0, 0, 1, 0, 32'h10,  32'hDEAD_BEEF, 5'd0);
      ops[1] = mk(1, 1, 0, 1, 32'h10,  32'h0, 5'd2);
      ops[2] = mk(1, 1, 0, 1, 32'h410, 32'h0, 5'd3);
      for (int i = 0; i < 3; i++) begin
         run_op(0, ops[i], got, nst, bub);
         e = sb.pop_front();
         n_checks++;
         if (got !== e.o) begin
            n_fail++;
            $display("FAIL store_load[%0d]: got %h, expected %h", i, got, e.o);
         end
         n_checks++;
         if (nst !== e.nst || bub !== 0) begin
            n_fail++;
            $display("FAIL store_load_stall[%0d]: stalls %0d bad_bubbles %0d, expected %0d/0", i, nst, bub, e.nst);
         end
      end
   endtask

   task automatic test_passthrough;
      op_t  ops [2];
      out_t got;
      int   nst, bub;
      sb_t  e;
      ops[0] = mk(1, 0, 0, 0, 32'h0000_00A5, 32'h1, 5'd9);
      ops[1] = mk(0, 1, 0, 0, 32'hFFFF_FFFF, 32'h2, 5'd31);
      for (int i = 0; i < 2; i++) begin
         run_op(0, ops[i], got, nst, bub);
         e = sb.pop_front();
         n_checks++;
         if (got !== e.o) begin
            n_fail++;
            $display("FAIL passthrough[%0d]: got %h, expected %h", i, got, e.o);
         end
         n_checks++;
         if (nst !== 0) begin
            n_fail++;
            $display("FAIL passthrough_stall[%0d]: stalls %0d, expected 0", i, nst);
         end
      end
   endtask

   task automatic test_illegal;
      op_t  ops [2];
      out_t got;
      int   nst, bub;
      sb_t  e;
      ops[0] = mk(1, 1, 1, 1, 32'h4, 32'h55, 5'd6);
      ops[1] = mk(1, 1, 0, 1, 32'h4, 32'h0,  5'd7);
      for (int i = 0; i < 2; i++) begin
         run_op(0, ops[i], got, nst, bub);
         e = sb.pop_front();
         n_checks++;
         if (got !== e.o) begin
            n_fail++;
            $display("FAIL illegal_rw[%0d]: got %h, expected %h", i, got, e.o);
         end
      end
   endtask

   task automatic test_multi_cycle;
      op_t  ops [3];
      out_t got;
      int   nst, bub;
      sb_t  e;
      ops[0] = mk(0, 0, 1, 0, 32'h20, 32'h0000_1234, 5'd0);
      ops[1] = mk(1, 1, 0, 1, 32'h20, 32'h0, 5'd7);
      ops[2] = mk(1, 0, 0, 0, 32'h77, 32'h0, 5'd8);
      for (int i = 0; i < 3; i++) begin
         run_op(1, ops[i], got, nst, bub);
         e = sb.pop_front();
         n_checks++;
         if (got !== e.o) begin
            n_fail++;
            $display("FAIL multi_cycle[%0d]: got %h, expected %h", i, got, e.o);
         end
         n_checks++;
         if (nst !== e.nst) begin
            n_fail++;
            $display("FAIL multi_cycle_stalls[%0d]: got %0d, expected %0d", i, nst, e.nst);
         end
         n_checks++;
         if (bub !== 0) begin
            n_fail++;
            $display("FAIL multi_cycle_bubble[%0d]: %0d bad bubble cycles, expected 0", i, bub);
         end
      end
   endtask

   task automatic test_reset_mid;
      out_t got;
      int   nst, bub;
      sb_t  e;
      run_op(2, mk(0, 0, 1, 0, 32'h8, 32'h0000_1111, 5'd0), got, nst, bub);
      e = sb.pop_front();
      n_checks++;
      if (got !== e.o || nst !== e.nst) begin
         n_fail++;
         $display("FAIL reset_mid_prestore: got %h/%0d, expected %h/%0d", got, nst, e.o, e.nst);
      end
      drv[2] = mk(0, 0, 1, 0, 32'h8, 32'h0000_CAFE, 5'd0);
      @(negedge clk);
      n_checks++;
      if (stall_a[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_stall1: got %b, expected 1", stall_a[2]);
      end
      @(posedge clk); #1;
      rst_a[2] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (stall_a[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_stall_drop: got %b, expected 0", stall_a[2]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (obs[2] !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got %h, expected 0", obs[2]);
      end
      rst_a[2] = 1'b0;
      drv[2]   = '0;
      run_op(2, mk(1, 1, 0, 1, 32'h8, 32'h0, 5'd12), got, nst, bub);
      e = sb.pop_front();
      n_checks++;
      if (got !== e.o) begin
         n_fail++;
         $display("FAIL reset_mid_dropped_write: got %h, expected %h", got, e.o);
      end
      n_checks++;
      if (nst !== 3 || bub !== 0) begin
         n_fail++;
         $display("FAIL reset_mid_reload_stall: stalls %0d bad_bubbles %0d, expected 3/0", nst, bub);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_store_load();
      test_passthrough();
      test_illegal();
      test_multi_cycle();
      test_reset_mid();
      n_checks++;
      if (sb.size() !== 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the EX/MEM pipeline register.
- Consumes EX/MEM outputs, performs data-memory load/store with configurable access latency, and registers results into MEM/WB outputs for writeback.
- Raises Stall to freeze the upstream pipeline while a multi-cycle access is in flight.

Parameters:
- DEPTH, 256, data-memory depth in 32-bit words (power of two).
- ADDR_W, 8, word-index width, equal to log2(DEPTH).
- MEM_LAT, 1, cycles per load/store access (>=1); 1 means no stall.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- RegWrite  in  1  from EX/MEM RegWriteOut
- MemtoReg  in  1  from EX/MEM MemtoRegOut
- MemWrite  in  1  from EX/MEM MemWriteOut
- MemRead  in  1  from EX/MEM MemReadOut
- Result  in  32  ALU result / byte address (EX/MEM ResultOut)
- RtData  in  32  store data (EX/MEM RtDataOut)
- MuxIn  in  5  destination register (EX/MEM MuxOut)
- RegWriteOut  out  1  MEM/WB write enable
- MemtoRegOut  out  1  MEM/WB writeback select
- ReadDataOut  out  32  registered load data
- ResultOut  out  32  registered ALU result
- MuxOut  out  5  registered destination register
- Stall  out  1  combinational; upstream holds EX/MEM contents while 1

Behaviour:
- Reset (rst=1 at posedge): all registered outputs are 0, counter is 0, state is IDLE. Stall is forced to 0 while rst=1. Memory contents are not cleared.
- Reset mid-access: the counter is cleared and any pending store is dropped (no write occurs).
- Access request: acc = MemRead | MemWrite. Word index = Result[ADDR_W+1:2]. Bits [1:0] are ignored. Upper bits are ignored, so addresses wrap modulo DEPTH.
- FSM with counter cnt (width enough for MEM_LAT-1):
  - IDLE (cnt=0): if acc and MEM_LAT>1, go to WAIT with cnt<=1. If acc and MEM_LAT=1, complete this cycle.
  - WAIT: if cnt==MEM_LAT-1, complete this cycle, then cnt<=0 and return to IDLE. Otherwise cnt<=cnt+1.
  - Complete cycle: at that posedge, a store writes RtData to mem[index], and a load captures mem[index] into ReadDataOut.
- Stall = acc & ~complete & ~rst. An access therefore stalls for exactly MEM_LAT-1 cycles.
- Outputs while stalled: the MEM/WB outputs load a bubble every stalled cycle:
  - RegWriteOut=0, MemtoRegOut=0
  - ResultOut, MuxOut, ReadDataOut hold their previous values
- Outputs on non-stalled cycles:
  - RegWriteOut<=RegWrite, MemtoRegOut<=MemtoReg, ResultOut<=Result, MuxOut<=MuxIn.
  - ReadDataOut<=mem[index] if MemRead, else 0.
- Latency: non-memory ops take 1 cycle to reach the outputs. Loads and stores take MEM_LAT cycles.
- MemRead and MemWrite both 1 (illegal): the store executes and ReadDataOut<=0.
- Store followed by load to the same word: the load returns the new data, because the write committed at the earlier edge.
- Memory read is asynchronous into the output register; the write is synchronous. The block does no forwarding.
- Upstream contract: while Stall=1, the EX/MEM inputs must stay stable. Input changes during Stall have undefined effect.

Decomposition:
- Shared package mem_pkg holds:
  - state enum {IDLE, WAIT}
  - default MEM_LAT and DEPTH constants
  - function clog2 for ADDR_W
- Sub-module data_mem: DEPTH x 32 array, synchronous write enable, asynchronous read port.
- mem_stage instantiates data_mem and contains the FSM, Stall logic and the MEM/WB register.

Test Plan:
- Reset: rst=1 for 2 cycles while MemRead=1 -> Stall=0, all outputs 0.
- Passthrough (MEM_LAT=1): RegWrite=1, Result=0x0000_00A5, MuxIn=5'd9, no memory op -> next cycle RegWriteOut=1, ResultOut=0xA5, MuxOut=9, ReadDataOut=0, Stall never asserted.
- Store/load (MEM_LAT=1): store RtData=0xDEAD_BEEF at Result=0x10, then load at 0x10 with MemtoReg=1 -> ReadDataOut=0xDEADBEEF one cycle after the load. Repeat the load at 0x410 with DEPTH=256 -> same data (wrap).
- Multi-cycle (MEM_LAT=3): load at 0x20 holding 0x1234 -> Stall=1 for exactly 2 cycles with RegWriteOut=0 bubbles, then ReadDataOut=0x1234 and RegWriteOut=1. A following ALU op proceeds with no stall.
- Reset mid-access (MEM_LAT=4): store 0xCAFE to 0x8, assert rst in the 2nd stalled cycle -> Stall drops, outputs 0. A later load of 0x8 returns the old value (write dropped).
- Illegal MemRead=MemWrite=1 at 0x4 with RtData=0x55 -> mem[1]=0x55, ReadDataOut=0.
